ram_read_streamer: RTL and testbench

- Single-clock read-side sequencer that sits directly downstream of the dual-clock RAM's read port, in the read-clock domain.
- On a start command it sweeps a contiguous address range, issuing read addresses and compensating for the RAM's fixed 2-cycle read latency.
- Returns the words as a valid/ready stream through a small credit-controlled buffer, so consumer back-pressure never loses a word.
- Typical consumers: video scan-out, DMA-out and core message readers.

---
 rtl/ram_read_streamer.sv | 184 ++++++++++++++++++
 tb/tb_ram_read_streamer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_read_streamer.sv
// Sweeps a contiguous RAM address range and streams the words out over valid/ready.
// Latency: first out_valid three cycles after the accepted start (1 latch + 2 RAM read latency).
// Backpressure: issues are credit-limited by buffer occupancy plus in-flight reads, so no word is ever dropped.
module ram_read_streamer #(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 12,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Sequencer state
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   issue_rem_q, issue_rem_d;
  logic [ADDR_WIDTH:0]   accept_rem_q, accept_rem_d;
  logic                  zero_done_q, zero_done_d;

  // RAM read-latency tracking
  logic                  issue_d1_q, issue_d2_q;

  // Output buffer
  logic [DATA_WIDTH-1:0] buf_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;

  // Datapath strobes
  logic                  start_acc;
  logic                  credit_ok;
  logic                  issue;
  logic                  buf_empty;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic                  final_accept;
  logic [CW:0]           credit_used;

  // Credit: words buffered plus reads still travelling through the RAM pipe.
  assign credit_used = {1'b0, count_q} + (CW+1)'(issue_d1_q) + (CW+1)'(issue_d2_q);
  assign credit_ok   = credit_used < (CW+1)'(DEPTH);

  assign start_acc = start && (state_q == S_IDLE);
  assign issue     = (state_q == S_ISSUE) && (issue_rem_q != '0) && credit_ok;

  // The buffer is fall-through: when it is empty the word arriving from the
  // RAM is presented directly, which is what gives the 3-cycle first-word
  // latency. If that word is not taken it is written and shows up as the head.
  assign buf_empty = (count_q == '0);
  assign out_valid = !buf_empty || issue_d2_q;
  assign out_data  = buf_empty ? ram_data_in : buf_q[rd_ptr_q];
  assign accept    = out_valid && out_ready;
  assign pop       = accept && !buf_empty;
  assign push      = issue_d2_q && !(buf_empty && accept);

  // Done fires combinationally with the last handshake so busy is still high
  // in that cycle; a length-0 command reports done one cycle after start.
  assign final_accept  = accept && (state_q != S_IDLE) && (accept_rem_q == (ADDR_WIDTH+1)'(1));
  assign done          = final_accept || zero_done_q;
  assign busy          = (state_q != S_IDLE);
  assign ram_read_addr = addr_q;

  // Next-state logic for the sweep sequencer and its counters
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_rem_d  = issue_rem_q;
    accept_rem_d = accept_rem_q;
    zero_done_d  = 1'b0;

    if (accept && (accept_rem_q != '0)) begin
      accept_rem_d = accept_rem_q - (ADDR_WIDTH+1)'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          if (length == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d      = S_ISSUE;
            addr_d       = start_addr;
            issue_rem_d  = length;
            accept_rem_d = length;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          addr_d      = addr_q + ADDR_WIDTH'(1);
          issue_rem_d = issue_rem_q - (ADDR_WIDTH+1)'(1);
          if (issue_rem_q == (ADDR_WIDTH+1)'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (final_accept) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Buffer occupancy follows pushes and pops; simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Sequencer and address registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      issue_rem_q  <= '0;
      accept_rem_q <= '0;
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_rem_q  <= issue_rem_d;
      accept_rem_q <= accept_rem_d;
      zero_done_q  <= zero_done_d;
    end
  end

  // Two-stage valid pipe mirroring the RAM's read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_d1_q <= 1'b0;
      issue_d2_q <= 1'b0;
    end else begin
      issue_d1_q <= issue;
      issue_d2_q <= issue_d1_q;
    end
  end

  // Output buffer storage and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        buf_q[wr_ptr_q] <= ram_data_in;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // The credit rule guarantees the buffer never overflows.
  assert property (@(posedge clk) disable iff (reset) count_q <= CW'(DEPTH));
  assert property (@(posedge clk) disable iff (reset) !(push && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_ram_read_streamer.sv
module tb_ram_read_streamer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [11:0] start_addr;
  logic [12:0] length;
  logic        busy;
  logic        done;
  logic [11:0] ram_read_addr;
  logic [7:0]  ram_data_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  ram_read_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .FIFO_DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .ram_read_addr(ram_read_addr), .ram_data_in(ram_data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // RAM model: address seen during cycle c returns data during cycle c+2.
  logic [7:0] mem [4096];
  logic [7:0] p1, p2;
  always @(posedge clk) begin
    p1 <= mem[ram_read_addr];
    p2 <= p1;
  end
  assign ram_data_in = p2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  bit   m_busy = 0;
  int   m_rem = 0;
  bit   zero_pend = 0;
  bit   mon_en = 0;
  bit   stall_prev = 0;
  logic [7:0] prev_data;
  int   cyc = 0;
  int   start_cyc = 0;
  int   first_vld_cyc = -1;
  int   last_hs_cyc = 0;
  int   done_cnt = 0;
  int   acc_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Per-cycle scoreboard, evaluated mid-cycle with inputs already settled.
  task automatic monitor();
    logic hs;
    logic exp_done;
    logic [7:0] w;
    cyc++;
    if (!mon_en) return;
    hs = out_valid && out_ready;
    exp_done = zero_pend;
    zero_pend = 1'b0;
    check("busy", busy, m_busy);
    if (!m_busy) check("idle_valid", out_valid, 0);
    if (stall_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
    end
    stall_prev = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("extra_word", 1, 0);
      end else begin
        w = exp_q.pop_front();
        check("data", out_data, w);
        acc_cnt++;
        last_hs_cyc = cyc;
        m_rem--;
        if (m_rem == 0) begin
          exp_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
    check("done", done, exp_done);
    if (done) done_cnt++;
    if (start && !m_busy) begin
      start_cyc = cyc;
      first_vld_cyc = -1;
      if (length == 0) begin
        zero_pend = 1'b1;
      end else begin
        m_rem = int'(length);
        for (int k = 0; k < int'(length); k++) exp_q.push_back(mem[(int'(start_addr) + k) & 12'hFFF]);
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_idle();
    return !m_busy && !zero_pend && exp_q.size() == 0;
  endfunction

  task automatic run_until_idle(input int bound, input bit rnd_ready, input bit poke_start);
    int n = 0;
    while (!model_idle() && n < bound) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_start && m_busy && $urandom_range(0, 7) == 0) begin
        start = 1'b1;
        start_addr = 12'($urandom);
        length = 13'($urandom_range(1, 50));
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("idle_reached", model_idle(), 1);
    tick();
  endtask

  task automatic issue_start(input logic [11:0] a, input logic [12:0] len);
    start_addr = a;
    length = len;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int d0;
    int a0;
    int n;
    logic [11:0] diff;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i & 8'hFF);
    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    length = '0;
    out_ready = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_addr", ram_read_addr, 0);
    tick();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    tick();

    // 1: basic sweep, latency and burst
    d0 = done_cnt;
    issue_start(12'h010, 13'd8);
    run_until_idle(60, 0, 0);
    check("first_valid_lat", first_vld_cyc - start_cyc, 3);
    check("burst_span", last_hs_cyc - first_vld_cyc, 7);
    check("done_cnt_t1", done_cnt - d0, 1);

    // 2: address wrap
    issue_start(12'hFFE, 13'd4);
    for (int j = 0; j < 4; j++) begin
      check("rd_addr_wrap", ram_read_addr, 12'((12'hFFE + j) & 12'hFFF));
      tick();
    end
    run_until_idle(60, 0, 0);

    // 3: consumer stall, credit limit
    d0 = done_cnt;
    a0 = acc_cnt;
    issue_start(12'h100, 13'd16);
    out_ready = 1'b0;
    repeat (20) tick();
    diff = ram_read_addr - 12'h100;
    check("stall_issues", diff, 4);
    run_until_idle(100, 0, 0);
    check("stall_words", acc_cnt - a0, 16);
    check("done_cnt_t3", done_cnt - d0, 1);

    // 4: random backpressure, ignored starts while busy
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    d0 = done_cnt;
    a0 = acc_cnt;
    out_ready = 1'($urandom_range(0, 1));
    issue_start(12'($urandom), 13'd100);
    run_until_idle(2000, 1, 1);
    check("rand_words", acc_cnt - a0, 100);
    check("done_cnt_t4", done_cnt - d0, 1);

    // 5: zero-length command
    d0 = done_cnt;
    issue_start(12'h123, 13'd0);
    tick();
    tick();
    check("done_cnt_zero", done_cnt - d0, 1);

    // 6: reset mid-sweep, then a fresh sweep
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    issue_start(12'($urandom), 13'd20);
    n = 0;
    while (m_rem > 15 && n < 60) begin
      tick();
      n++;
    end
    check("mid_accepts", m_rem, 15);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_addr", ram_read_addr, 0);
    mon_en = 1'b0;
    exp_q.delete();
    m_busy = 1'b0;
    m_rem = 0;
    zero_pend = 1'b0;
    stall_prev = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    tick();
    d0 = done_cnt;
    a0 = acc_cnt;
    issue_start(12'($urandom), 13'd3);
    run_until_idle(60, 0, 0);
    check("post_rst_words", acc_cnt - a0, 3);
    check("done_cnt_t6", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
